mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous block RAM (1-cycle read latency) between the instruction-fetch path and the load/store path of the RISC-V core.
- Arbitrates each cycle and drives the RAM port.
- Generates byte-lane write enables for SB/SH/SW and sign- or zero-extends load data for LB/LH/LW/LBU/LHU.
- Returns one response per accepted request, one cycle after grant.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch and load/store.
// Data has priority, a burst limit guarantees fetch progress, and every grant gets a response one cycle later.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_D_BURST = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    input  logic [2:0]            d_funct3,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    localparam int BW = $clog2(MAX_D_BURST + 2);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

    typedef enum logic { OWNER_IF = 1'b0, OWNER_D = 1'b1 } owner_e;

    logic [BW-1:0] burst_q, burst_d;
    logic          rsp_valid_q, rsp_valid_d;
    owner_e        rsp_owner_q, rsp_owner_d;
    logic          rsp_we_q, rsp_we_d;
    logic [2:0]    rsp_funct3_q, rsp_funct3_d;
    logic [1:0]    rsp_off_q, rsp_off_d;
    logic          rsp_err_q, rsp_err_d;

    logic fetch_forced, if_win, d_win;
    logic d_illegal, d_misaligned, d_bad;
    logic [31:0] lane_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_WIDTH+2], if_addr[1:0], d_addr[31:ADDR_WIDTH+2]};

    always_comb begin : request_check
        d_illegal    = 1'b0;
        d_misaligned = 1'b0;
        if (d_we) begin
            d_illegal = (d_funct3 > 3'b010);
        end else begin
            d_illegal = (d_funct3 == 3'b011) || (d_funct3 == 3'b110) || (d_funct3 == 3'b111);
        end
        case (d_funct3[1:0])
            2'b01:   d_misaligned = d_addr[0];
            2'b10:   d_misaligned = (d_addr[1:0] != 2'b00);
            default: d_misaligned = 1'b0;
        endcase
        d_bad = d_illegal | d_misaligned;
    end

    // Winners are computed ungated; the flops are held in reset, only the outputs need gating.
    always_comb begin : arbitrate
        fetch_forced = if_req && (burst_q == BURST_MAX);
        d_win        = d_req && !fetch_forced;
        if_win       = if_req && !d_win;
    end

    always_comb begin : next_state
        burst_d = burst_q;
        if (!if_req || if_win) begin
            burst_d = '0;
        end else if (d_win && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + 1'b1;
        end
        rsp_valid_d  = if_win | d_win;
        rsp_owner_d  = d_win ? OWNER_D : OWNER_IF;
        rsp_we_d     = d_win & d_we;
        rsp_funct3_d = d_funct3;
        rsp_off_d    = d_addr[1:0];
        rsp_err_d    = d_win & d_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= OWNER_IF;
            rsp_we_q     <= 1'b0;
            rsp_funct3_q <= 3'b000;
            rsp_off_q    <= 2'b00;
            rsp_err_q    <= 1'b0;
        end else begin
            burst_q      <= burst_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_we_q     <= rsp_we_d;
            rsp_funct3_q <= rsp_funct3_d;
            rsp_off_q    <= rsp_off_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Errored data requests are consumed without touching the RAM.
    always_comb begin : ram_port
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_win) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[ADDR_WIDTH+1:2];
        end else if (d_win && !d_bad) begin
            mem_en   = 1'b1;
            mem_addr = d_addr[ADDR_WIDTH+1:2];
            if (d_we) begin
                case (d_funct3[1:0])
                    2'b00: begin
                        mem_we    = 4'b0001 << d_addr[1:0];
                        mem_wdata = {4{d_wdata[7:0]}};
                    end
                    2'b01: begin
                        mem_we    = 4'b0011 << d_addr[1:0];
                        mem_wdata = {2{d_wdata[15:0]}};
                    end
                    default: begin
                        mem_we    = 4'b1111;
                        mem_wdata = d_wdata;
                    end
                endcase
            end
        end
        if (!rst_n) begin
            mem_en    = 1'b0;
            mem_we    = 4'b0000;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    assign if_gnt    = if_win & rst_n;
    assign d_gnt     = d_win & rst_n;
    assign if_rvalid = rsp_valid_q && (rsp_owner_q == OWNER_IF);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rvalid  = rsp_valid_q && (rsp_owner_q == OWNER_D);
    assign d_err     = d_rvalid & rsp_err_q;

    always_comb begin : load_format
        lane_data = mem_rdata >> {rsp_off_q, 3'b000};
        d_rdata   = 32'h0;
        if (d_rvalid && !rsp_we_q && !rsp_err_q) begin
            case (rsp_funct3_q)
                3'b000:  d_rdata = {{24{lane_data[7]}}, lane_data[7:0]};
                3'b001:  d_rdata = {{16{lane_data[15]}}, lane_data[15:0]};
                3'b010:  d_rdata = mem_rdata;
                3'b100:  d_rdata = {24'h0, lane_data[7:0]};
                3'b101:  d_rdata = {16'h0, lane_data[15:0]};
                default: d_rdata = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM model on the memory port, a word-level reference memory,
// and an expected-response queue that every cycle's grant feeds.
module tb_mem_port_arbiter;
  localparam int AW   = 12;
  localparam int MAXB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req, d_we;
  logic [31:0]   d_addr, d_wdata;
  logic [2:0]    d_funct3;
  logic          d_gnt, d_rvalid, d_err;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(int i);
    if (i == 5) return 32'h00A00093;
    return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // RAM model: synchronous, byte-writable, loaded once during the first reset.
  logic [31:0] ram [0:(1<<AW)-1];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rst_n && !ram_loaded) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= seed_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [34:0] exp_q[$];   // {owner: 01=IF 10=D, err, data}
  int          burst_model;
  int          n_checks = 0;
  int          n_err    = 0;
  logic        m_if_gnt, m_d_gnt;
  logic [31:0] cap_if_rdata, cap_d_rdata;
  logic        cap_if_rvalid, cap_d_rvalid, cap_d_err, cap_if_gnt, cap_d_gnt, cap_mem_en;
  logic [3:0]  cap_mem_we;
  logic [AW-1:0] cap_mem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic req_error(logic we, logic [2:0] f3, logic [1:0] off);
    logic legal, mis;
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis   = (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
    return !legal || mis;
  endfunction

  function automatic logic [31:0] load_value(logic [31:0] word, logic [2:0] f3, logic [1:0] off);
    int nbytes;
    logic [31:0] v, keep;
    nbytes = 1 << f3[1:0];
    v = word >> (8 * int'(off));
    if (nbytes < 4) begin
      keep = (32'h1 << (8 * nbytes)) - 32'h1;
      v = v & keep;
      if (!f3[2] && v[8*nbytes-1]) v = v | ~keep;
    end
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_if_gnt"},    if_gnt, 0);
    check({tag, "_if_rvalid"}, if_rvalid, 0);
    check({tag, "_if_rdata"},  if_rdata, 0);
    check({tag, "_d_gnt"},     d_gnt, 0);
    check({tag, "_d_rvalid"},  d_rvalid, 0);
    check({tag, "_d_rdata"},   d_rdata, 0);
    check({tag, "_d_err"},     d_err, 0);
    check({tag, "_mem_en"},    mem_en, 0);
    check({tag, "_mem_we"},    mem_we, 0);
    check({tag, "_mem_addr"},  mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // One clock: inputs are already driven (at the negedge); check, model, advance.
  task automatic step();
    logic [34:0]   e;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          err;
    logic [3:0]    exp_we;
    logic [31:0]   lane_mask, exp_bytes;
    int            nbytes, lane;
    #1;
    cap_if_rdata = if_rdata;   cap_d_rdata = d_rdata;   cap_if_rvalid = if_rvalid;
    cap_d_rvalid = d_rvalid;   cap_d_err = d_err;       cap_if_gnt = if_gnt;
    cap_d_gnt = d_gnt;         cap_mem_en = mem_en;     cap_mem_we = mem_we;
    cap_mem_addr = mem_addr;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("if_rvalid", if_rvalid, e[34:33] == 2'b01);
      check("d_rvalid", d_rvalid, e[34:33] == 2'b10);
      if (e[34:33] == 2'b01) check("if_rdata", if_rdata, e[31:0]);
      else begin
        check("d_err", d_err, e[32]);
        check("d_rdata", d_rdata, e[31:0]);
      end
    end else begin
      check("idle_if_rvalid", if_rvalid, 0);
      check("idle_d_rvalid", d_rvalid, 0);
    end
    m_d_gnt  = d_req && !(if_req && burst_model == MAXB);
    m_if_gnt = if_req && !m_d_gnt;
    check("if_gnt", if_gnt, m_if_gnt);
    check("d_gnt", d_gnt, m_d_gnt);
    if (m_if_gnt) begin
      idx = if_addr[AW+1:2];
      check("if_mem_en", mem_en, 1);
      check("if_mem_we", mem_we, 0);
      check("if_mem_addr", mem_addr, idx);
      exp_q.push_back({2'b01, 1'b0, ref_mem[idx]});
    end else if (m_d_gnt) begin
      idx = d_addr[AW+1:2];
      off = d_addr[1:0];
      err = req_error(d_we, d_funct3, off);
      if (err) begin
        check("err_mem_en", mem_en, 0);
        exp_q.push_back({2'b10, 1'b1, 32'h0});
      end else begin
        check("d_mem_en", mem_en, 1);
        check("d_mem_addr", mem_addr, idx);
        if (d_we) begin
          nbytes = 1 << d_funct3[1:0];
          exp_we = 4'b0000; lane_mask = 32'h0; exp_bytes = 32'h0;
          for (int k = 0; k < nbytes; k++) begin
            lane = int'(off) + k;
            exp_we[lane] = 1'b1;
            lane_mask[8*lane +: 8] = 8'hFF;
            exp_bytes[8*lane +: 8] = d_wdata[8*k +: 8];
            ref_mem[idx][8*lane +: 8] = d_wdata[8*k +: 8];
          end
          check("st_mem_we", mem_we, exp_we);
          check("st_mem_wdata", mem_wdata & lane_mask, exp_bytes);
          exp_q.push_back({2'b10, 1'b0, 32'h0});
        end else begin
          check("ld_mem_we", mem_we, 0);
          exp_q.push_back({2'b10, 1'b0, load_value(ref_mem[idx], d_funct3, off)});
        end
      end
    end else begin
      check("idle_mem_en", mem_en, 0);
    end
    if (!if_req || m_if_gnt) burst_model = 0;
    else if (m_d_gnt && burst_model < MAXB) burst_model++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive_d(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
  endtask

  task automatic random_d();
    logic [1:0] off;
    d_req    = ($urandom_range(0, 99) < 70);
    d_we     = $urandom_range(0, 1);
    d_funct3 = $urandom_range(0, 7);
    off      = $urandom_range(0, 1) ? 2'd0 : 2'($urandom_range(0, 3));
    d_addr   = ($urandom << 14) | (32'($urandom_range(0, 15)) << 2) | 32'(off);
    d_wdata  = $urandom;
  endtask

  task automatic random_if();
    if_req  = ($urandom_range(0, 99) < 60);
    if_addr = ($urandom << 14) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed_word(i);
    burst_model = 0;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h14;
    drive_d(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
    step();

    // Fetch only
    if_req = 1'b1; if_addr = 32'h14;
    step();
    check("fetch_gnt", cap_if_gnt, 1);
    check("fetch_mem_addr", cap_mem_addr, 12'd5);
    if_req = 1'b0;
    step();
    check("fetch_rvalid", cap_if_rvalid, 1);
    check("fetch_rdata", cap_if_rdata, 32'h00A00093);

    // Store / load lanes
    drive_d(1'b1, 3'b000, 32'h103, 32'hFF);
    step();
    check("sb_mem_we", cap_mem_we, 4'b1000);
    drive_d(1'b0, 3'b000, 32'h103, 32'h0);
    step();
    drive_d(1'b0, 3'b100, 32'h103, 32'h0);
    step();
    check("lb_rdata", cap_d_rdata, 32'hFFFFFFFF);
    drive_d(1'b1, 3'b001, 32'h102, 32'h8001);
    step();
    check("lbu_rdata", cap_d_rdata, 32'h000000FF);
    drive_d(1'b0, 3'b001, 32'h102, 32'h0);
    step();
    d_req = 1'b0;
    step();
    check("lh_rdata", cap_d_rdata, 32'hFFFF8001);

    // Errors
    drive_d(1'b0, 3'b010, 32'h102, 32'h0);
    step();
    check("mis_d_gnt", cap_d_gnt, 1);
    check("mis_mem_en", cap_mem_en, 0);
    drive_d(1'b1, 3'b011, 32'h40, 32'h12345678);
    step();
    check("mis_rsp_err", cap_d_err, 1);
    check("mis_rsp_rdata", cap_d_rdata, 0);
    check("ill_mem_en", cap_mem_en, 0);
    d_req = 1'b0;
    step();
    check("ill_rsp_valid", cap_d_rvalid, 1);
    check("ill_rsp_err", cap_d_err, 1);

    // Back-to-back throughput
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_d(1'b0, 3'b010, 32'h100 + 32'(4 * i), 32'h0);
      else d_req = 1'b0;
      step();
      if (i > 0) check("b2b_rvalid", cap_d_rvalid, 1);
    end
    step();

    // Contention: D,D,IF repeating
    if_req = 1'b1; if_addr = 32'h14;
    for (int i = 0; i < 9; i++) begin
      drive_d(1'b0, 3'b010, 32'h100 + 32'(4 * (i % 4)), 32'h0);
      step();
      check("cont_if_gnt", cap_if_gnt, (i % 3) == 2);
      if (m_if_gnt) if_addr = if_addr + 32'h4;
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
    step();

    // Randomized traffic
    random_if();
    random_d();
    for (int c = 0; c < 400; c++) begin
      step();
      if (m_if_gnt || !if_req) random_if();
      if (m_d_gnt || !d_req) random_d();
    end
    if_req = 1'b0; d_req = 1'b0;
    step();
    step();

    // Reset mid-flight
    drive_d(1'b0, 3'b010, 32'h104, 32'h0);
    #1 check("midrst_d_gnt", d_gnt, 1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midrst_in");
    @(posedge clk);
    #1 check_all_zero("midrst_edge");
    @(negedge clk);
    d_req = 1'b0; rst_n = 1'b1;
    exp_q.delete();
    burst_model = 0;
    step();
    step();
    check("midrst_no_rvalid", cap_d_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
